// File: rtl/regfile_writeback_queue_pkg.sv
// Shared constants for the register-file writeback queue.
//   REG_ADDR_W / REG_DATA_W : default register address / data widths
//   REG_COUNT               : number of architectural registers (width of the pending mask)
//   ZERO_REG                : hard-wired zero register; writes to it are dropped
package regfile_writeback_queue_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned ZERO_REG   = 0;

endpackage

// File: rtl/regfile_writeback_queue_wb_fifo.sv
// Circular buffer with two push ports (push0 is the older request) and one pop port.
// Every slot is exposed in age order so the owner can build pending masks and lookups.
//   clk, rst_n            : clock, asynchronous active-low reset (pointers/count only)
//   push0, push0_addr/data: first (older) push
//   push1, push1_addr/data: second (younger) push; lands after push0 when both fire
//   pop                   : remove head; caller guarantees count > 0
//   count                 : number of valid entries
//   ent_valid/addr/data   : entries in age order, index 0 = head (oldest)
module regfile_writeback_queue_wb_fifo #(
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  ADDR_W = 5,
  parameter int unsigned  DATA_W = 32,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push0,
  input  logic [ADDR_W-1:0]              push0_addr,
  input  logic [DATA_W-1:0]              push0_data,
  input  logic                           push1,
  input  logic [ADDR_W-1:0]              push1_addr,
  input  logic [DATA_W-1:0]              push1_data,
  input  logic                           pop,
  output logic [CNT_W-1:0]               count,
  output logic [DEPTH-1:0]               ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]   ent_data
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q, push1_ptr;
  logic [CNT_W-1:0]             count_q, count_d;

  // The younger push takes the slot after the older one only when both fire.
  assign push1_ptr = push0 ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

  // Entry storage carries no reset; validity comes from count and pointers.
  always_ff @(posedge clk) begin
    if (push0) begin
      addr_q[wr_ptr_q] <= push0_addr;
      data_q[wr_ptr_q] <= push0_data;
    end
    if (push1) begin
      addr_q[push1_ptr] <= push1_addr;
      data_q[push1_ptr] <= push1_data;
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      wr_ptr_q <= wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_valid[k] = CNT_W'(k) < count_q;
      ent_addr[k]  = addr_q[rd_ptr_q + PTR_W'(k)];
      ent_data[k]  = data_q[rd_ptr_q + PTR_W'(k)];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-side master for the 32x32 register file. Buffers MEM and ALU writeback requests in
// order and commits one per clock through registered RegWrite/write_reg_addr/write_data.
//   mem_wb_valid/addr/data, mem_wb_ready : load writeback request (older when both arrive)
//   alu_wb_valid/addr/data, alu_wb_ready : ALU writeback request
//   RegWrite, write_reg_addr, write_data : registered register-file write port
//   wb_pending                            : bit r set while r is queued or committing
//   lookupN_addr -> lookupN_hit/data      : youngest in-flight value for a register
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  ADDR_W = REG_ADDR_W,
  parameter int unsigned  DATA_W = REG_DATA_W,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_wb_valid,
  input  logic [ADDR_W-1:0]    mem_wb_addr,
  input  logic [DATA_W-1:0]    mem_wb_data,
  output logic                 mem_wb_ready,
  input  logic                 alu_wb_valid,
  input  logic [ADDR_W-1:0]    alu_wb_addr,
  input  logic [DATA_W-1:0]    alu_wb_data,
  output logic                 alu_wb_ready,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    write_reg_addr,
  output logic [DATA_W-1:0]    write_data,
  output logic [REG_COUNT-1:0] wb_pending,
  input  logic [ADDR_W-1:0]    lookup1_addr,
  output logic                 lookup1_hit,
  output logic [DATA_W-1:0]    lookup1_data,
  input  logic [ADDR_W-1:0]    lookup2_addr,
  output logic                 lookup2_hit,
  output logic [DATA_W-1:0]    lookup2_data
);

  logic [CNT_W-1:0]             count;
  logic                         mem_push, alu_push, pop;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic                         regwrite_q;
  logic [ADDR_W-1:0]            wr_addr_q;
  logic [DATA_W-1:0]            wr_data_q;

  // Readiness uses the registered count only, so a same-cycle pop earns no credit and
  // the ALU port always leaves room for a simultaneous MEM push.
  assign mem_wb_ready = count <= CNT_W'(DEPTH - 1);
  assign alu_wb_ready = count <= CNT_W'(DEPTH - 2);

  // Writes to the zero register are acknowledged but never enter the queue.
  assign mem_push = mem_wb_valid && mem_wb_ready && (mem_wb_addr != ADDR_W'(ZERO_REG));
  assign alu_push = alu_wb_valid && alu_wb_ready && (alu_wb_addr != ADDR_W'(ZERO_REG));
  assign pop      = count != '0;

  regfile_writeback_queue_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wb_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push0      (mem_push),
    .push0_addr (mem_wb_addr),
    .push0_data (mem_wb_data),
    .push1      (alu_push),
    .push1_addr (alu_wb_addr),
    .push1_data (alu_wb_data),
    .pop        (pop),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr),
    .ent_data   (ent_data)
  );

  // Output stage: head moves here on every edge the queue is non-empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else if (pop) begin
      regwrite_q <= 1'b1;
      wr_addr_q  <= ent_addr[0];
      wr_data_q  <= ent_data[0];
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  assign RegWrite       = regwrite_q;
  assign write_reg_addr = wr_addr_q;
  assign write_data     = wr_data_q;

  always_comb begin
    wb_pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k]) wb_pending[ent_addr[k]] = 1'b1;
    end
    if (regwrite_q) wb_pending[wr_addr_q] = 1'b1;
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    lookup1_hit  = 1'b0;
    lookup1_data = '0;
    lookup2_hit  = 1'b0;
    lookup2_data = '0;
    if (regwrite_q) begin
      if (wr_addr_q == lookup1_addr) begin
        lookup1_hit  = 1'b1;
        lookup1_data = wr_data_q;
      end
      if (wr_addr_q == lookup2_addr) begin
        lookup2_hit  = 1'b1;
        lookup2_data = wr_data_q;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && ent_addr[k] == lookup1_addr) begin
        lookup1_hit  = 1'b1;
        lookup1_data = ent_data[k];
      end
      if (ent_valid[k] && ent_addr[k] == lookup2_addr) begin
        lookup2_hit  = 1'b1;
        lookup2_data = ent_data[k];
      end
    end
    if (lookup1_addr == ADDR_W'(ZERO_REG)) begin
      lookup1_hit  = 1'b0;
      lookup1_data = '0;
    end
    if (lookup2_addr == ADDR_W'(ZERO_REG)) begin
      lookup2_hit  = 1'b0;
      lookup2_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: a queue-based reference model checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_wb_valid = 1'b0, alu_wb_valid = 1'b0;
  logic [4:0]  mem_wb_addr = '0, alu_wb_addr = '0;
  logic [31:0] mem_wb_data = '0, alu_wb_data = '0;
  logic        mem_wb_ready, alu_wb_ready;
  logic        RegWrite;
  logic [4:0]  write_reg_addr;
  logic [31:0] write_data;
  logic [31:0] wb_pending;
  logic [4:0]  lookup1_addr = '0, lookup2_addr = '0;
  logic        lookup1_hit, lookup2_hit;
  logic [31:0] lookup1_data, lookup2_data;

  regfile_writeback_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (5),
    .DATA_W (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_wb_valid   (mem_wb_valid),
    .mem_wb_addr    (mem_wb_addr),
    .mem_wb_data    (mem_wb_data),
    .mem_wb_ready   (mem_wb_ready),
    .alu_wb_valid   (alu_wb_valid),
    .alu_wb_addr    (alu_wb_addr),
    .alu_wb_data    (alu_wb_data),
    .alu_wb_ready   (alu_wb_ready),
    .RegWrite       (RegWrite),
    .write_reg_addr (write_reg_addr),
    .write_data     (write_data),
    .wb_pending     (wb_pending),
    .lookup1_addr   (lookup1_addr),
    .lookup1_hit    (lookup1_hit),
    .lookup1_data   (lookup1_data),
    .lookup2_addr   (lookup2_addr),
    .lookup2_hit    (lookup2_hit),
    .lookup2_data   (lookup2_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  // Reference model state.
  ent_t        mq[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          mem_acc, alu_acc;
  int          m_commits = 0;

  // Register file written from the DUT's write port.
  logic [31:0] rf[32];
  int          dut_commits = 0;
  always @(posedge clk) begin
    if (RegWrite) begin
      rf[write_reg_addr] <= write_data;
      dut_commits        <= dut_commits + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rw    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    mem_acc = 1'b0;
    alu_acc = 1'b0;
  endtask

  // One clock edge: the head commits if anything was queued before the edge, then the
  // accepted non-zero requests join the back, MEM ahead of ALU.
  task automatic model_edge();
    int   free;
    ent_t e;
    free    = DEPTH - mq.size();
    mem_acc = mem_wb_valid && free >= 1;
    alu_acc = alu_wb_valid && free >= 2;
    if (mq.size() > 0) begin
      e      = mq.pop_front();
      m_rw   = 1'b1;
      m_addr = e.addr;
      m_data = e.data;
      m_commits++;
    end else begin
      m_rw = 1'b0;
    end
    if (mem_acc && mem_wb_addr != 0) begin
      e.addr = mem_wb_addr;
      e.data = mem_wb_data;
      mq.push_back(e);
    end
    if (alu_acc && alu_wb_addr != 0) begin
      e.addr = alu_wb_addr;
      e.data = alu_wb_data;
      mq.push_back(e);
    end
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].addr] = 1'b1;
    if (m_rw) p[m_addr] = 1'b1;
    return p;
  endfunction

  // Returns {hit, data}; searches youngest queued entry first, then the committing one.
  function automatic logic [32:0] m_lookup(input logic [4:0] a);
    if (a == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == a) return {1'b1, mq[i].data};
    end
    if (m_rw && m_addr == a) return {1'b1, m_data};
    return '0;
  endfunction

  logic [32:0] lk1, lk2;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("RegWrite", RegWrite, m_rw);
        check("write_reg_addr", write_reg_addr, m_addr);
        check("write_data", write_data, m_data);
        check("mem_wb_ready", mem_wb_ready, (DEPTH - mq.size()) >= 1);
        check("alu_wb_ready", alu_wb_ready, (DEPTH - mq.size()) >= 2);
        check("wb_pending", wb_pending, m_pending());
        lk1 = m_lookup(lookup1_addr);
        lk2 = m_lookup(lookup2_addr);
        check("lookup1_hit", lookup1_hit, lk1[32]);
        check("lookup1_data", lookup1_data, lk1[31:0]);
        check("lookup2_hit", lookup2_hit, lk2[32]);
        check("lookup2_data", lookup2_data, lk2[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
  endtask

  task automatic drive(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad);
    mem_wb_valid = mv;
    mem_wb_addr  = ma;
    mem_wb_data  = md;
    alu_wb_valid = av;
    alu_wb_addr  = aa;
    alu_wb_data  = ad;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  int c0, mi, ai;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    model_reset();
    // Requests asserted during reset must be ignored.
    drive(1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
    for (int i = 0; i < 3; i++) tick();
    rst_n  = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    check("reset RegWrite", RegWrite, 1'b0);
    check("reset write_data", write_data, 32'h0);
    check("reset wb_pending", wb_pending, 32'h0);
    check("reset mem_wb_ready", mem_wb_ready, 1'b1);
    check("reset alu_wb_ready", alu_wb_ready, 1'b1);
    idle(2);
    check("no commit from reset-time requests", dut_commits, 0);

    // Single ALU request: visible on the write port for one cycle after edge k+1.
    lookup2_addr = 5'd5;
    drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t2 RegWrite after k", RegWrite, 1'b0);
    check("t2 pending r5", wb_pending[5], 1'b1);
    tick();
    check("t2 RegWrite after k+1", RegWrite, 1'b1);
    check("t2 addr", write_reg_addr, 5'd5);
    check("t2 data", write_data, 32'hDEADBEEF);
    tick();
    check("t2 RegWrite after k+2", RegWrite, 1'b0);
    idle(2);

    // Same-cycle MEM and ALU to r3: MEM is older, ALU value wins.
    lookup1_addr = 5'd3;
    lookup2_addr = 5'd4;
    drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t3 lookup1 hit", lookup1_hit, 1'b1);
    check("t3 lookup1 data", lookup1_data, 32'h22);
    tick();
    check("t3 first commit", write_data, 32'h11);
    check("t3 lookup1 data while first commits", lookup1_data, 32'h22);
    tick();
    check("t3 second commit", write_data, 32'h22);
    tick();
    check("t3 rf r3", rf[3], 32'h22);
    idle(2);

    // Both ports valid every cycle: count goes 0 -> 2 -> 3 and stays, ALU held off.
    c0 = dut_commits;
    mi = 0;
    ai = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive(1, 5'(1 + mi), 32'hA000_0000 + mi, 1, 5'(16 + ai), 32'hB000_0000 + ai);
      tick();
      if (mem_acc) mi++;
      if (alu_acc) ai++;
      if (cyc == 0) begin
        check("t4 mem_ready at count 2", mem_wb_ready, 1'b1);
        check("t4 alu_ready at count 2", alu_wb_ready, 1'b1);
      end
      if (cyc == 1) begin
        check("t4 mem_ready at count 3", mem_wb_ready, 1'b1);
        check("t4 alu_ready at count 3", alu_wb_ready, 1'b0);
      end
    end
    idle(6);
    check("t4 accepted mem", mi, 10);
    check("t4 accepted alu", ai, 2);
    check("t4 commit count", dut_commits - c0, 12);

    // Write to r0: accepted, never committed, never pending, lookups miss.
    lookup1_addr = 5'd0;
    lookup2_addr = 5'd0;
    drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    #1;
    check("t5 alu_ready", alu_wb_ready, 1'b1);
    c0 = dut_commits;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t5 pending r0", wb_pending[0], 1'b0);
    check("t5 lookup1 hit", lookup1_hit, 1'b0);
    tick();
    check("t5 RegWrite", RegWrite, 1'b0);
    tick();
    check("t5 no commit", dut_commits - c0, 0);

    // Push and pop on the same edge at count 2.
    lookup1_addr = 5'd8;
    lookup2_addr = 5'd9;
    drive(1, 5'd7, 32'h70, 1, 5'd8, 32'h80);
    tick();
    check("t6 pending before", wb_pending, 32'h0000_0180);
    drive(1, 5'd9, 32'h90, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("t6 pending after", wb_pending, 32'h0000_0380);
    check("t6 commit addr", write_reg_addr, 5'd7);
    check("t6 alu_ready (count 2)", alu_wb_ready, 1'b1);
    check("t6 lookup2 data", lookup2_data, 32'h90);
    idle(4);

    // Reset mid-cycle with three entries queued.
    drive(1, 5'd10, 32'hA, 1, 5'd11, 32'hB);
    tick();
    drive(1, 5'd12, 32'hC, 1, 5'd13, 32'hD);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t1 RegWrite in reset", RegWrite, 1'b0);
    check("t1 pending in reset", wb_pending, 32'h0);
    check("t1 mem_ready in reset", mem_wb_ready, 1'b1);
    check("t1 alu_ready in reset", alu_wb_ready, 1'b1);
    tick();
    c0 = dut_commits;
    rst_n = 1'b1;
    idle(5);
    check("t1 no commits after reset", dut_commits - c0, 0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
